// File: rtl/uart_rx.sv
// uart_rx: 8N1 LSB-first serial receiver with mid-bit sampling, framing-error detect and line resync.
module uart_rx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] dataByte,
  output logic       dataReady,
  output logic       frameErr,
  output logic       busy
);
  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_END = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(HALF_BIT - 1);
  if (CLKS_PER_BIT < 4) begin : g_bad_rate
    $error("uart_rx: CLKS_PER_BIT must be >= 4");
  end
  typedef enum logic [2:0] {RESYNC, IDLE, START, DATA, STOP} state_t;
  state_t state, state_n;
  logic [1:0] sync;
  logic rx_s;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] idx, idx_n;
  logic [7:0] shift, shift_n, byte_n;
  logic ready_n, err_n;
  assign rx_s = sync[1];
  assign busy = (state == START) || (state == DATA) || (state == STOP);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      sync      <= 2'b11;
      state     <= RESYNC;
      cnt       <= '0;
      idx       <= '0;
      shift     <= '0;
      dataByte  <= '0;
      dataReady <= 1'b0;
      frameErr  <= 1'b0;
    end else begin
      sync      <= {sync[0], rx};
      state     <= state_n;
      cnt       <= cnt_n;
      idx       <= idx_n;
      shift     <= shift_n;
      dataByte  <= byte_n;
      dataReady <= ready_n;
      frameErr  <= err_n;
    end
  // Every state exit clears the counter; IDLE keeps it parked at zero.
  always_comb begin
    state_n = state;
    cnt_n   = cnt + 1'b1;
    idx_n   = idx;
    shift_n = shift;
    byte_n  = dataByte;
    ready_n = 1'b0;
    err_n   = 1'b0;
    case (state)
      RESYNC:
        if (!rx_s) cnt_n = '0;
        else if (cnt == FULL_END) begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      IDLE: begin
        cnt_n = '0;
        if (!rx_s) state_n = START;
      end
      START:
        if (cnt == HALF_END) begin
          cnt_n   = '0;
          idx_n   = '0;
          state_n = rx_s ? IDLE : DATA;
        end
      DATA:
        if (cnt == FULL_END) begin
          cnt_n        = '0;
          shift_n[idx] = rx_s;
          idx_n        = idx + 1'b1;
          if (idx == 3'd7) state_n = STOP;
        end
      STOP:
        if (cnt == FULL_END) begin
          cnt_n   = '0;
          state_n = rx_s ? IDLE : RESYNC;
          ready_n = rx_s;
          err_n   = !rx_s;
          byte_n  = rx_s ? shift : dataByte;
        end
      default: begin
        state_n = RESYNC;
        cnt_n   = '0;
      end
    endcase
  end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized frame stimulus checked every cycle against a frame-level expectation queue.
module tb_uart_rx;
  localparam int C = 16;
  localparam int HALF = C / 2;
  localparam int LAT = 2 + HALF + 9 * C + 1;
  logic clk = 1'b0, reset = 1'b1, rx = 1'b1;
  logic [7:0] dataByte;
  logic dataReady, frameErr, busy;
  int checks = 0, errors = 0, cyc = 0;
  logic [7:0] exp_b[$];
  bit exp_ok[$];
  int exp_due[$];
  logic [7:0] model_byte = 8'h00;
  int rdy_cnt = 0, err_cnt = 0, busy_cnt = 0, busy_run = 0;
  int pulse_cyc[$];
  logic [7:0] pulse_byte[$];

  uart_rx #(.CLKS_PER_BIT(C)) dut (
    .clk(clk), .reset(reset), .rx(rx), .dataByte(dataByte),
    .dataReady(dataReady), .frameErr(frameErr), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic chk_near(input string name, input int got, input int want);
    checks++;
    if (got < want - 1 || got > want + 1) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d +/-1 (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Frame-level reference: each sent frame predicts one pulse of a known kind at fall + LAT.
  always @(negedge clk) begin
    if (reset) begin
      chk("reset_dataByte", dataByte, 0);
      chk("reset_dataReady", dataReady, 0);
      chk("reset_frameErr", frameErr, 0);
      chk("reset_busy", busy, 0);
      exp_b.delete();
      exp_ok.delete();
      exp_due.delete();
      model_byte = 8'h00;
      busy_run = 0;
    end else begin
      chk("ready_and_err_together", int'(dataReady && frameErr), 0);
      if (dataReady || frameErr) begin
        rdy_cnt += int'(dataReady);
        err_cnt += int'(frameErr);
        if (exp_b.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse: dataReady=%0b frameErr=%0b with no frame outstanding (cycle %0d)",
                   dataReady, frameErr, cyc);
        end else begin
          chk_near("pulse_time", cyc, exp_due[0]);
          chk("pulse_is_ready", dataReady, exp_ok[0]);
          if (exp_ok[0]) begin
            model_byte = exp_b[0];
            pulse_cyc.push_back(cyc);
            pulse_byte.push_back(dataByte);
          end
          void'(exp_b.pop_front());
          void'(exp_ok.pop_front());
          void'(exp_due.pop_front());
        end
      end else if (exp_b.size() > 0 && cyc > exp_due[0] + 1) begin
        checks++;
        errors++;
        $display("FAIL missed_pulse: byte %02h ok=%0b due at %0d, no pulse by %0d",
                 exp_b[0], exp_ok[0], exp_due[0], cyc);
        void'(exp_b.pop_front());
        void'(exp_ok.pop_front());
        void'(exp_due.pop_front());
      end
      chk("dataByte", dataByte, model_byte);
      if (busy) begin
        busy_cnt++;
        busy_run++;
      end else begin
        if (busy_run > 0) chk("busy_run_too_long", int'(busy_run > HALF + 9 * C), 0);
        busy_run = 0;
      end
    end
  end

  task automatic send_frame(input logic [7:0] b, input bit ok, output int t0);
    int off;
    logic [9:0] bits;
    off = $urandom_range(1, 8);
    bits = {ok, b, 1'b0};
    #off;
    t0 = cyc;
    exp_b.push_back(b);
    exp_ok.push_back(ok);
    exp_due.push_back(cyc + LAT);
    for (int i = 0; i < 10; i++) begin
      if (i > 0) #off;
      rx = bits[i];
      repeat (C) @(posedge clk);
    end
  endtask

  task automatic line_high(input int n);
    #($urandom_range(1, 8));
    rx = 1'b1;
    repeat (n) @(posedge clk);
  endtask

  task automatic glitch(input int len);
    int off, b0;
    off = $urandom_range(1, 8);
    b0 = busy_cnt;
    #off;
    rx = 1'b0;
    repeat (len) @(posedge clk);
    #off;
    rx = 1'b1;
    repeat (24) @(posedge clk);
    chk("glitch_busy_cycles", busy_cnt - b0, HALF);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_b.size() > 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    chk("outstanding_frames", exp_b.size(), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int t0, r, gap;
    logic [7:0] b;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    repeat (C + 4) @(posedge clk);
    send_frame(8'hA5, 1'b1, t0);
    drain();
    chk("s1_pulse_count", pulse_cyc.size(), 1);
    if (pulse_cyc.size() > 0) chk_near("s1_latency", pulse_cyc[pulse_cyc.size()-1] - t0, 155);
    chk("s1_dataByte", dataByte, 8'hA5);
    chk("s1_frameErr_count", err_cnt, 0);
    send_frame(8'h00, 1'b1, t0);
    drain();
    chk("s2_dataByte", dataByte, 8'h00);
    chk("s2_ready_count", rdy_cnt, 2);
    glitch(5);
    chk("s3_ready_count", rdy_cnt, 2);
    chk("s3_err_count", err_cnt, 0);
    send_frame(8'h3C, 1'b0, t0);
    repeat (48) @(posedge clk);
    line_high(C + 4);
    drain();
    chk("s4_err_count", err_cnt, 1);
    chk("s4_ready_count", rdy_cnt, 2);
    chk("s4_dataByte_kept", dataByte, 8'h00);
    send_frame(8'h5A, 1'b1, t0);
    drain();
    chk("s4_dataByte_after", dataByte, 8'h5A);
    pulse_cyc.delete();
    pulse_byte.delete();
    for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1, t0);
    drain();
    chk("s5_pulse_count", pulse_cyc.size(), 4);
    if (pulse_cyc.size() == 4)
      for (int i = 0; i < 4; i++) begin
        chk("s5_order", pulse_byte[i], i + 1);
        if (i > 0) chk("s5_spacing", pulse_cyc[i] - pulse_cyc[i-1], 160);
      end
    #3 rx = 1'b0;
    repeat (C) @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      #3 rx = 1'b1;
      repeat (C) @(posedge clk);
    end
    repeat (HALF) @(posedge clk);
    #3;
    chk("s6_busy_before_reset", busy, 1);
    reset = 1'b1;
    #1;
    chk("s6_dataByte_cleared", dataByte, 8'h00);
    chk("s6_dataReady_cleared", dataReady, 0);
    chk("s6_frameErr_cleared", frameErr, 0);
    chk("s6_busy_cleared", busy, 0);
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    repeat (C + 4) @(posedge clk);
    send_frame(8'h81, 1'b1, t0);
    drain();
    chk("s6_dataByte", dataByte, 8'h81);
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 9);
      b = 8'($urandom_range(0, 255));
      if (r < 2) glitch($urandom_range(1, 5));
      else if (r == 2) begin
        send_frame(b, 1'b0, t0);
        repeat ($urandom_range(0, 40)) @(posedge clk);
        line_high(C + 4);
      end else begin
        send_frame(b, 1'b1, t0);
        gap = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 30);
        repeat (gap) @(posedge clk);
      end
    end
    drain();
    repeat (5) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
